// File: rtl/mos6502s_ea_sequencer.sv
// 6502-style effective-address sequencer.
// Fetches operand/pointer bytes over a ready-gated read port and forms the EA.
module mos6502s_ea_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  mode,
  input  logic [15:0] pc,
  input  logic [7:0]  x,
  input  logic [7:0]  y,
  input  logic [7:0]  mem_data,
  input  logic        mem_rdy,
  output logic        mem_rd,
  output logic [15:0] mem_addr,
  output logic        busy,
  output logic        done,
  output logic [15:0] ea,
  output logic        page_cross,
  output logic [1:0]  operand_len,
  output logic        load_full,
  output logic [15:0] latch_addr
);

  localparam logic [2:0] M_ZP   = 3'd0;
  localparam logic [2:0] M_ZPX  = 3'd1;
  localparam logic [2:0] M_ABS  = 3'd2;
  localparam logic [2:0] M_ABSX = 3'd3;
  localparam logic [2:0] M_ABSY = 3'd4;
  localparam logic [2:0] M_INDX = 3'd5;
  localparam logic [2:0] M_INDY = 3'd6;
  localparam logic [2:0] M_IND  = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_OP_LO,
    S_OP_HI,
    S_PTR_LO,
    S_PTR_HI,
    S_FINISH
  } state_t;

  state_t      state;
  state_t      nxt;
  logic [2:0]  mode_r;
  logic [15:0] pc_r;
  logic [7:0]  x_r;
  logic [7:0]  y_r;
  logic [7:0]  b0;
  logic [7:0]  lo;

  logic [7:0]  idx;
  logic        idx_mode;
  logic [15:0] base;
  logic [15:0] sum;
  logic [7:0]  zp_x;
  logic [15:0] fin_ea;
  logic        fin_pc;
  logic [1:0]  fin_len;
  logic [15:0] nxt_addr;

  // Next state, next read address and the EA result if this read finishes.
  always_comb begin
    idx      = 8'h00;
    idx_mode = 1'b0;
    case (mode_r)
      M_ABSX: begin
        idx      = x_r;
        idx_mode = 1'b1;
      end
      M_ABSY, M_INDY: begin
        idx      = y_r;
        idx_mode = 1'b1;
      end
      default: begin
        idx      = 8'h00;
        idx_mode = 1'b0;
      end
    endcase

    base = (state == S_PTR_HI) ? {mem_data, lo}
                               : {mem_data, b0};
    sum  = base + {8'h00, idx};
    zp_x = mem_data + x_r;

    if (state == S_OP_LO) begin
      fin_ea = (mode_r == M_ZPX) ? {8'h00, zp_x}
                                 : {8'h00, mem_data};
    end else begin
      fin_ea = sum;
    end
    fin_pc = idx_mode && (state != S_OP_LO) &&
             (sum[15:8] != base[15:8]);

    case (mode_r)
      M_ABS, M_ABSX, M_ABSY, M_IND: fin_len = 2'd2;
      default:                      fin_len = 2'd1;
    endcase

    nxt      = state;
    nxt_addr = 16'h0000;
    case (state)
      S_OP_LO: begin
        case (mode_r)
          M_ZP, M_ZPX: nxt = S_FINISH;
          M_INDX: begin
            nxt      = S_PTR_LO;
            nxt_addr = {8'h00, zp_x};
          end
          M_INDY: begin
            nxt      = S_PTR_LO;
            nxt_addr = {8'h00, mem_data};
          end
          default: begin
            nxt      = S_OP_HI;
            nxt_addr = pc_r + 16'd1;
          end
        endcase
      end
      S_OP_HI: begin
        if (mode_r == M_IND) begin
          nxt      = S_PTR_LO;
          nxt_addr = {mem_data, b0};
        end else begin
          nxt = S_FINISH;
        end
      end
      S_PTR_LO: begin
        // high byte is kept: zero page for INDX/INDY, JMP page-wrap bug for IND
        nxt      = S_PTR_HI;
        nxt_addr = {mem_addr[15:8], mem_addr[7:0] + 8'd1};
      end
      S_PTR_HI: nxt = S_FINISH;
      default:  nxt = state;
    endcase
  end

  // Sequencer state and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      mode_r      <= 3'd0;
      pc_r        <= 16'h0000;
      x_r         <= 8'h00;
      y_r         <= 8'h00;
      b0          <= 8'h00;
      lo          <= 8'h00;
      mem_rd      <= 1'b0;
      mem_addr    <= 16'h0000;
      busy        <= 1'b0;
      done        <= 1'b0;
      ea          <= 16'h0000;
      page_cross  <= 1'b0;
      operand_len <= 2'd0;
      load_full   <= 1'b0;
      latch_addr  <= 16'h0000;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_OP_LO;
            mode_r   <= mode;
            pc_r     <= pc;
            x_r      <= x;
            y_r      <= y;
            mem_rd   <= 1'b1;
            mem_addr <= pc;
            busy     <= 1'b1;
          end
        end
        S_OP_LO, S_OP_HI, S_PTR_LO, S_PTR_HI: begin
          if (mem_rdy) begin
            if (state == S_OP_LO)  b0 <= mem_data;
            if (state == S_PTR_LO) lo <= mem_data;
            state <= nxt;
            if (nxt == S_FINISH) begin
              mem_rd      <= 1'b0;
              mem_addr    <= 16'h0000;
              done        <= 1'b1;
              load_full   <= 1'b1;
              latch_addr  <= fin_ea;
              ea          <= fin_ea;
              page_cross  <= fin_pc;
              operand_len <= fin_len;
            end else begin
              mem_addr <= nxt_addr;
            end
          end
        end
        S_FINISH: begin
          state      <= S_IDLE;
          busy       <= 1'b0;
          done       <= 1'b0;
          load_full  <= 1'b0;
          latch_addr <= 16'h0000;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mos6502s_ea_sequencer.sv
// Randomized bench for mos6502s_ea_sequencer.
// A behavioural memory/EA model predicts reads, results and latency.
module tb_mos6502s_ea_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  mode;
  logic [15:0] pc;
  logic [7:0]  x;
  logic [7:0]  y;
  logic [7:0]  mem_data;
  logic        mem_rdy;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic        busy;
  logic        done;
  logic [15:0] ea;
  logic        page_cross;
  logic [1:0]  operand_len;
  logic        load_full;
  logic [15:0] latch_addr;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] mem [int];
  logic [7:0] salt = 8'h00;

  mos6502s_ea_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .pc(pc),
    .x(x), .y(y), .mem_data(mem_data), .mem_rdy(mem_rdy),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .busy(busy), .done(done),
    .ea(ea), .page_cross(page_cross), .operand_len(operand_len),
    .load_full(load_full), .latch_addr(latch_addr)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] rd(input logic [15:0] a);
    logic [7:0] h;
    if (mem.exists(int'(a))) return mem[int'(a)];
    h = a[15:8];
    h = h * 8'd3;
    return (a[7:0] ^ h) + salt;
  endfunction

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, a, e);
    end
  endtask

  task automatic rand_inputs();
    start = 1'($urandom);
    mode  = 3'($urandom);
    pc    = 16'($urandom);
    x     = 8'($urandom);
    y     = 8'($urandom);
  endtask

  // Runs one sequence from IDLE (caller sits at a negedge).
  // stall < 0: random stalls; otherwise exactly that many per read.
  task automatic run_seq(input logic [2:0] m, input logic [15:0] p,
                         input logic [7:0] xi, input logic [7:0] yi,
                         input int stall, output int lat);
    logic [15:0] q[$];
    logic [15:0] e, base;
    logic        pcx;
    logic [1:0]  len;
    logic [7:0]  b0, b1, t, t2;
    logic        rdy;
    int          stalls;

    q.delete();
    q.push_back(p);
    b0  = rd(p);
    pcx = 1'b0;
    len = (m inside {3'd2, 3'd3, 3'd4, 3'd7}) ? 2'd2 : 2'd1;
    e   = 16'h0000;
    case (m)
      3'd0: e = {8'h00, b0};
      3'd1: begin
        t = b0 + xi;
        e = {8'h00, t};
      end
      3'd2, 3'd3, 3'd4: begin
        q.push_back(p + 16'd1);
        b1   = rd(p + 16'd1);
        base = {b1, b0};
        t    = (m == 3'd3) ? xi : (m == 3'd4) ? yi : 8'h00;
        e    = base + {8'h00, t};
        pcx  = (e[15:8] != b1);
      end
      3'd5: begin
        t  = b0 + xi;
        t2 = t + 8'd1;
        q.push_back({8'h00, t});
        q.push_back({8'h00, t2});
        e = {rd({8'h00, t2}), rd({8'h00, t})};
      end
      3'd6: begin
        t = b0 + 8'd1;
        q.push_back({8'h00, b0});
        q.push_back({8'h00, t});
        base = {rd({8'h00, t}), rd({8'h00, b0})};
        e    = base + {8'h00, yi};
        pcx  = (e[15:8] != base[15:8]);
      end
      default: begin
        b1 = rd(p + 16'd1);
        t  = b0 + 8'd1;
        q.push_back(p + 16'd1);
        q.push_back({b1, b0});
        q.push_back({b1, t});
        e = {rd({b1, t}), rd({b1, b0})};
      end
    endcase

    start   = 1'b1;
    mode    = m;
    pc      = p;
    x       = xi;
    y       = yi;
    mem_rdy = 1'($urandom);
    mem_data = 8'($urandom);
    @(posedge clk);
    lat    = 1;
    stalls = 0;
    @(negedge clk);

    foreach (q[k]) begin
      for (int s = 0; ; s++) begin
        chk("rd_busy", 32'(busy), 32'd1);
        chk("rd_memrd", 32'(mem_rd), 32'd1);
        chk("rd_addr", 32'(mem_addr), 32'(q[k]));
        chk("rd_done", 32'(done | load_full), 32'd0);
        if (stall < 0) rdy = (s >= 6) || ($urandom_range(0, 3) != 0);
        else           rdy = (s >= stall);
        mem_rdy  = rdy;
        mem_data = rdy ? rd(mem_addr) : 8'($urandom);
        rand_inputs();
        @(posedge clk);
        lat++;
        @(negedge clk);
        if (rdy) break;
        stalls++;
      end
    end

    chk("fin_done", 32'(done), 32'd1);
    chk("fin_load", 32'(load_full), 32'd1);
    chk("fin_latch", 32'(latch_addr), 32'(e));
    chk("fin_ea", 32'(ea), 32'(e));
    chk("fin_pcross", 32'(page_cross), 32'(pcx));
    chk("fin_len", 32'(operand_len), 32'(len));
    chk("fin_busy", 32'(busy), 32'd1);
    chk("fin_rd", 32'({mem_rd, mem_addr}), 32'd0);
    chk("latency", 32'(lat), 32'(q.size() + 1 + stalls));

    rand_inputs();
    mem_rdy = 1'($urandom);
    @(posedge clk);
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_pulse", 32'({done, load_full, latch_addr}), 32'd0);
    chk("idle_rd", 32'({mem_rd, mem_addr}), 32'd0);
    chk("hold_ea", 32'({ea, page_cross, operand_len}),
        32'({e, pcx, len}));
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("fin_start_ignored", 32'(busy), 32'd0);
  endtask

  initial begin
    int lat;
    logic [7:0] p8;

    rst = 1'b1; start = 1'b1; mode = 3'd2; pc = 16'h1234;
    x = 8'h00; y = 8'h00; mem_data = 8'h00; mem_rdy = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("reset_state", 32'({busy, mem_rd, done, load_full, page_cross}), 32'd0);
    chk("reset_vals", 32'({mem_addr, ea}), 32'd0);
    chk("reset_len", 32'({operand_len, latch_addr}), 32'd0);
    rst = 1'b0; start = 1'b0;
    @(posedge clk);
    @(negedge clk);

    mem.delete();
    mem[32'h0200] = 8'h34;
    mem[32'h0201] = 8'h12;
    run_seq(3'd2, 16'h0200, 8'h00, 8'h00, 0, lat);
    chk("abs_lat", 32'(lat), 32'd3);
    chk("abs_ea", 32'(ea), 32'h1234);
    chk("abs_len", 32'({page_cross, operand_len}), 32'd2);

    mem[32'h0300] = 8'hF0;
    run_seq(3'd1, 16'h0300, 8'h20, 8'h00, 0, lat);
    chk("zpx_lat", 32'(lat), 32'd2);
    chk("zpx_ea", 32'(ea), 32'h0010);
    chk("zpx_len", 32'(operand_len), 32'd1);

    mem[32'h0400] = 8'hF0;
    mem[32'h0401] = 8'h12;
    run_seq(3'd3, 16'h0400, 8'h20, 8'h00, 0, lat);
    chk("absx_ea", 32'({ea, page_cross}), 32'({16'h1310, 1'b1}));
    run_seq(3'd3, 16'h0400, 8'h0F, 8'h00, 0, lat);
    chk("absx_ea_nc", 32'({ea, page_cross}), 32'({16'h12FF, 1'b0}));

    mem[32'h0500] = 8'hFF;
    mem[32'h0501] = 8'h30;
    mem[32'h30FF] = 8'hCD;
    mem[32'h3000] = 8'hAB;
    mem[32'h3100] = 8'hEE;
    run_seq(3'd7, 16'h0500, 8'h00, 8'h00, 0, lat);
    chk("ind_lat", 32'(lat), 32'd5);
    chk("ind_ea", 32'(ea), 32'hABCD);

    mem[32'h0600] = 8'h40;
    mem[32'h0040] = 8'hFF;
    mem[32'h0041] = 8'h10;
    run_seq(3'd6, 16'h0600, 8'h00, 8'h01, 2, lat);
    chk("indy_lat", 32'(lat), 32'd10);
    chk("indy_ea", 32'({ea, page_cross}), 32'({16'h1100, 1'b1}));

    // reset during PTR_LO of INDX
    mem.delete();
    salt = 8'h5A;
    start = 1'b1; mode = 3'd5; pc = 16'h0700; x = 8'h11;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; mem_rdy = 1'b1; mem_data = rd(mem_addr);
    p8 = rd(16'h0700) + 8'h11;
    @(posedge clk);
    @(negedge clk);
    chk("indx_ptr_addr", 32'(mem_addr), 32'({8'h00, p8}));
    rst = 1'b1; start = 1'b1; mem_rdy = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid_busy", 32'({busy, mem_rd, done, load_full}), 32'd0);
    chk("rst_mid_ea", 32'({ea, mem_addr}), 32'd0);
    rst = 1'b0; start = 1'b0; mem_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_no_done", 32'({busy, done, load_full}), 32'd0);
    end
    run_seq(3'd0, 16'h0800, 8'h00, 8'h00, 0, lat);
    chk("zp_after_rst_lat", 32'(lat), 32'd2);

    for (int i = 0; i < 200; i++) begin
      salt = 8'($urandom);
      run_seq(3'($urandom), 16'($urandom), 8'($urandom), 8'($urandom),
              -1, lat);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
